// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_ERR_CHECK_EN: reject divide-by-zero/overflow up front and raise err.
`timescale 1ns/1ps
module divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               err
);
   localparam int            CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] rem_r, rem_s;
   logic [WIDTH-1:0] q_r, q_s;
   logic [WIDTH-1:0] div_r, div_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             ready_r, ready_s;
   logic [WIDTH-1:0] quot_r, quot_s;
   logic [WIDTH-1:0] remo_r, remo_s;

   // The partial remainder only needs its extra top bit right after the shift, so it lives in shift_s.
   logic [WIDTH:0]   shift_s;
   logic [WIDTH-1:0] diff_s;
   logic             ge_s;

   assign shift_s = {rem_r, q_r[WIDTH-1]};
   assign ge_s    = (shift_s >= {1'b0, div_r});
   assign diff_s  = shift_s[WIDTH-1:0] - div_r;

`ifdef DIVIDER_ERR_CHECK_EN
   logic err_r, err_s;
   logic bad_s;
   assign bad_s = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
   assign err   = err_r;
`else
   assign err   = 1'b0;
`endif

   assign ready     = ready_r;
   assign quotient  = quot_r;
   assign remainder = remo_r;

   // Next-state and datapath update for the IDLE/CALC(/ERR) controller.
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      q_s     = q_r;
      div_s   = div_r;
      cnt_s   = cnt_r;
      ready_s = ready_r;
      quot_s  = quot_r;
      remo_s  = remo_r;
`ifdef DIVIDER_ERR_CHECK_EN
      err_s   = err_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               rem_s   = dividend[2*WIDTH-1:WIDTH];
               q_s     = dividend[WIDTH-1:0];
               div_s   = divisor;
               cnt_s   = '0;
               ready_s = 1'b0;
`ifdef DIVIDER_ERR_CHECK_EN
               if (bad_s) begin
                  state_s = ERR;
               end else begin
                  state_s = CALC;
               end
`else
               state_s = CALC;
`endif
            end else begin
               ready_s = 1'b1;
            end
         end
         CALC: begin
            rem_s = ge_s ? diff_s : shift_s[WIDTH-1:0];
            q_s   = {q_r[WIDTH-2:0], ge_s};
            cnt_s = cnt_r + CW'(1);
            if (cnt_r == LAST_ITER) begin
               state_s = IDLE;
               ready_s = 1'b1;
               quot_s  = q_s;
               remo_s  = rem_s;
`ifdef DIVIDER_ERR_CHECK_EN
               err_s   = 1'b0;
`endif
            end else begin
               state_s = CALC;
            end
         end
         ERR: begin
            state_s = IDLE;
            ready_s = 1'b1;
            quot_s  = '1;
            remo_s  = '0;
`ifdef DIVIDER_ERR_CHECK_EN
            err_s   = 1'b1;
`endif
         end
         default: begin
            state_s = IDLE;
            ready_s = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         rem_r   <= '0;
         q_r     <= '0;
         div_r   <= '0;
         cnt_r   <= '0;
         ready_r <= 1'b1;
         quot_r  <= '0;
         remo_r  <= '0;
`ifdef DIVIDER_ERR_CHECK_EN
         err_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         rem_r   <= rem_s;
         q_r     <= q_s;
         div_r   <= div_s;
         cnt_r   <= cnt_s;
         ready_r <= ready_s;
         quot_r  <= quot_s;
         remo_r  <= remo_s;
`ifdef DIVIDER_ERR_CHECK_EN
         err_r   <= err_s;
`endif
      end
   end
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: vector table, hand-written corner sequences and a random in-range sweep.
`timescale 1ns/1ps
module tb_divider_seq;
   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        ready;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        err;

   int errors = 0;
   int checks = 0;

   divider_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .ready     (ready),
      .quotient  (quotient),
      .remainder (remainder),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  q;
      logic [7:0]  r;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer division of the full dividend.
   function automatic void ref_div(input logic [15:0] dd, input logic [7:0] dv,
                                   output logic [7:0] q, output logic [7:0] r);
      int a;
      int b;
      a = int'(dd);
      b = int'(dv);
      q = 8'(a / b);
      r = 8'(a % b);
   endfunction

   // Counts negedges with ready low, starting at the negedge after the accepting edge.
   task automatic wait_done(output int lat);
      lat = 0;
      while (ready !== 1'b1 && lat < 64) begin
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r, output logic e, output int lat);
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      q = quotient;
      r = remainder;
      e = err;
   endtask

`ifdef DIVIDER_ERR_CHECK_EN
   localparam int ZLAT = 1;
   localparam logic [7:0] ZREM = 8'h00;
   localparam logic ZERR = 1'b1;
`else
   localparam int ZLAT = 8;
   localparam logic [7:0] ZREM = 8'h34;
   localparam logic ZERR = 1'b0;
`endif

   vec_t        vecs[8];
   logic [7:0]  q;
   logic [7:0]  r;
   logic        e;
   int          lat;
   logic [15:0] dd;
   logic [7:0]  dv;
   logic [7:0]  mq;
   logic [7:0]  mr;

   initial begin
      vecs[0] = '{16'd1000,  8'd7,    8'd142, 8'd6};
      vecs[1] = '{16'h00FF,  8'd1,    8'd255, 8'd0};
      vecs[2] = '{16'h7FFF,  8'hFF,   8'd128, 8'd127};
      vecs[3] = '{16'h0000,  8'd5,    8'd0,   8'd0};
      vecs[4] = '{16'hFEFF,  8'hFF,   8'd255, 8'd254};
      vecs[5] = '{16'h0001,  8'h80,   8'd0,   8'd1};
      vecs[6] = '{16'd100,   8'd10,   8'd10,  8'd0};
      vecs[7] = '{16'h1234,  8'h13,   8'd245, 8'd5};

      rst      = 1'b0;
      start    = 1'b0;
      dividend = 16'h0000;
      divisor  = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_quotient", {24'd0, quotient}, 32'd0);
      chk("reset_remainder", {24'd0, remainder}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].dd, vecs[i].dv, q, r, e, lat);
         chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, vecs[i].q});
         chk($sformatf("vec%0d_r", i), {24'd0, r}, {24'd0, vecs[i].r});
         chk($sformatf("vec%0d_err", i), {31'd0, e}, 32'd0);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
      end

      // Reset in the middle of a calculation.
      @(negedge clk);
      dividend = 16'd1000;
      divisor  = 8'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("midcalc_busy", {31'd0, ready}, 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_ready", {31'd0, ready}, 32'd1);
      chk("async_quotient", {24'd0, quotient}, 32'd0);
      chk("async_remainder", {24'd0, remainder}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(16'd1000, 8'd7, q, r, e, lat);
      chk("after_reset_q", {24'd0, q}, 32'd142);
      chk("after_reset_r", {24'd0, r}, 32'd6);
      chk("after_reset_lat", 32'(lat), 32'd8);

      // Back-to-back with start held high; inputs change while busy.
      @(negedge clk);
      dividend = 16'h00FF;
      divisor  = 8'd1;
      start    = 1'b1;
      @(negedge clk);
      dividend = 16'h7FFF;
      divisor  = 8'hFF;
      wait_done(lat);
      chk("b2b1_lat", 32'(lat), 32'd8);
      chk("b2b1_q", {24'd0, quotient}, 32'd255);
      chk("b2b1_r", {24'd0, remainder}, 32'd0);
      @(negedge clk);
      chk("b2b2_accepted", {31'd0, ready}, 32'd0);
      chk("b2b_hold_q", {24'd0, quotient}, 32'd255);
      chk("b2b_hold_r", {24'd0, remainder}, 32'd0);
      dividend = 16'hFFFF;
      divisor  = 8'd1;
      start    = 1'b0;
      wait_done(lat);
      chk("b2b2_lat", 32'(lat), 32'd8);
      chk("b2b2_q", {24'd0, quotient}, 32'd128);
      chk("b2b2_r", {24'd0, remainder}, 32'd127);

      // Divide by zero.
      run_op(16'h1234, 8'h00, q, r, e, lat);
      chk("div0_q", {24'd0, q}, 32'd255);
      chk("div0_r", {24'd0, r}, {24'd0, ZREM});
      chk("div0_err", {31'd0, e}, {31'd0, ZERR});
      chk("div0_lat", 32'(lat), 32'(ZLAT));

`ifdef DIVIDER_ERR_CHECK_EN
      // Overflow, then a valid operation clears err.
      run_op(16'h1234, 8'h12, q, r, e, lat);
      chk("ovf_q", {24'd0, q}, 32'd255);
      chk("ovf_r", {24'd0, r}, 32'd0);
      chk("ovf_err", {31'd0, e}, 32'd1);
      chk("ovf_lat", 32'(lat), 32'd1);
`endif
      run_op(16'd1000, 8'd7, q, r, e, lat);
      chk("recover_q", {24'd0, q}, 32'd142);
      chk("recover_r", {24'd0, r}, 32'd6);
      chk("recover_err", {31'd0, e}, 32'd0);

      // Random in-range sweep against the reference model.
      for (int n = 0; n < 1000; n++) begin
         dv = 8'($urandom_range(1, 255));
         dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
         dd[7:0]  = 8'($urandom);
         ref_div(dd, dv, mq, mr);
         run_op(dd, dv, q, r, e, lat);
         chk("sweep_q", {24'd0, q}, {24'd0, mq});
         chk("sweep_r", {24'd0, r}, {24'd0, mr});
         chk("sweep_identity",
             {31'd0, ((32'(q) * 32'(dv) + 32'(r)) == 32'(dd)) && (r < dv)}, 32'd1);
         chk("sweep_lat", 32'(lat), 32'd8);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Sequential restoring divider that inverts the team's 8x8 shift-add multiplier: a 2*WIDTH-bit dividend divided by a WIDTH-bit divisor gives a WIDTH-bit quotient and a WIDTH-bit remainder.
- Single module; controller and datapath are merged internally.
- Uses the same start/ready handshake as the multiplier, so both blocks can sit side by side in the arithmetic unit and share one sequencing scheme.
- Performs one quotient bit per clock.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only while ready=1
dividend  input  2*WIDTH  numerator; sampled on the accepting edge only
divisor  input  WIDTH  denominator; sampled on the accepting edge only
ready  output  1  1 = idle, results valid; 0 = busy
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
err  output  1  divide-by-zero/overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ready=1; quotient=0; remainder=0; err=0; internal registers and counter cleared. Any in-flight operation is abandoned. After release, the block idles until the next start.
- States: IDLE, CALC.
- IDLE:
  - ready=1.
  - On a clock edge with start=1: load partial remainder R (WIDTH+1 bits) = {0, dividend[2W-1:W]}; load Q = dividend[W-1:0]; latch the divisor into D; counter=0; go to CALC; ready=0 after this edge.
- CALC, one iteration per edge:
  - Shift {R,Q} left 1.
  - If R >= D: R = R - D and Q[0] = 1; else Q[0] = 0.
  - counter increments.
  - On the edge completing iteration WIDTH: quotient <= Q; remainder <= R[W-1:0]; state=IDLE; ready=1.
- Latency: ready is low for exactly WIDTH cycles after the accepting edge (8 for the default).
- quotient, remainder and err change only on completion. They hold the previous results throughout CALC.
- start while busy: ignored; no queuing.
- start held high continuously: a new operation is accepted on the edge after ready rises. Each result is visible for one cycle.
- Valid range: dividend[2W-1:W] < divisor. Results are then exact: dividend = quotient*divisor + remainder, with remainder < divisor.
- Out-of-range inputs without the macro: the algorithm runs unchanged for WIDTH cycles.
  - divisor=0 yields quotient = all ones and remainder = dividend[W-1:0].
  - Overflow with a nonzero divisor yields truncated values; the bench does not check them.

Optional Feature:
Macro DIVIDER_ERR_CHECK_EN.
- Defined:
  - On the accepting edge, the block tests divisor==0 or dividend[2W-1:W] >= divisor.
  - If either holds: skip CALC. The block spends one cycle in an ERR completion path with ready=0, then returns to IDLE with quotient = all ones, remainder = 0, err = 1.
  - err is cleared on the completion of the next valid operation.
- Undefined: err is tied to 0; the check logic is absent; out-of-range behaviour is as stated in Behaviour.

Test Plan:
1. Reset mid-CALC (dividend 1000, divisor 7, rst=0 at cycle 4) -> ready=1, quotient=0, remainder=0 immediately (asynchronous). A new start after release completes normally.
2. dividend 1000, divisor 7 -> ready low exactly 8 cycles; quotient=142, remainder=6, err=0.
3. Back-to-back, start held high: 0x00FF/1, then 0x7FFF/0xFF -> first quotient 255 r 0, then 128 r 127. The second operation is accepted the edge after ready rises; dividend/divisor changes during CALC have no effect.
4. Divide by zero, dividend 0x1234, divisor 0:
   - Without the macro -> after 8 cycles, quotient=0xFF, remainder=0x34, err=0.
   - With the macro -> after 1 cycle, quotient=0xFF, remainder=0, err=1.
5. Overflow with the macro, dividend 0x1234, divisor 0x12 -> 1-cycle completion with err=1. A following 1000/7 -> 142 r 6 and err=0.
6. Randomised sweep of 1000 in-range pairs against a reference model -> dividend == quotient*divisor + remainder and remainder < divisor on every completion.
